// File: rtl/control_msg_router_if.sv
// AXI-Stream bundle shared by the router's input and its per-port outputs.
// LANES > 1 packs several independent streams side by side; lane p of a
// field occupies slice [p*W +: W].
interface control_msg_router_if #(
  parameter int LANES  = 1,
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int DEST_W = 8,
  parameter int USER_W = 16
);
  logic [LANES-1:0]        tvalid;
  logic [LANES-1:0]        tready;
  logic [LANES*DATA_W-1:0] tdata;
  logic [LANES*KEEP_W-1:0] tkeep;
  logic [LANES*DEST_W-1:0] tid;
  logic [LANES*DEST_W-1:0] tdest;
  logic [LANES*USER_W-1:0] tuser;
  logic [LANES-1:0]        tlast;

  modport master (
    output tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tvalid, tdata, tkeep, tid, tdest, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/control_msg_router.sv
// Packet-aware control-message router. The first beat of each packet is
// decoded against a type table; the chosen output port is held until TLAST.
// Every output port owns a single full-throughput register slot. Packets of
// unknown type are swallowed and counted in a saturating drop counter.
module control_msg_router #(
  parameter int AXIS_DATA_WIDTH  = 64,
  parameter int AXIS_KEEP_WIDTH  = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_TDEST_WIDTH = 8,
  parameter int AXIS_TUSER_WIDTH = 16,
  parameter int MSG_TYPE_WIDTH   = 8,
  parameter int NUM_PORTS        = 2,
  parameter int NUM_TYPES        = 5,
  parameter logic [NUM_TYPES*MSG_TYPE_WIDTH-1:0] TYPE_CODES =
    {8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
  parameter logic [NUM_TYPES*3-1:0] TYPE_PORT =
    {3'd1, 3'd0, 3'd1, 3'd1, 3'd0},
  parameter int DROP_CNT_WIDTH   = 16
) (
  input  logic                      i_clk,
  input  logic                      i_ap_rst,
  control_msg_router_if.slave       from_network_bridge,
  control_msg_router_if.master      to_port,
  output logic [DROP_CNT_WIDTH-1:0] o_drop_count
);

  localparam int DW = AXIS_DATA_WIDTH;
  localparam int KW = AXIS_KEEP_WIDTH;
  localparam int IW = AXIS_TDEST_WIDTH;
  localparam int UW = AXIS_TUSER_WIDTH;
  localparam logic [3:0] NUM_PORTS_L = 4'(NUM_PORTS);

  typedef enum logic [1:0] {HEAD, FWD, DROP} state_t;

  state_t state_q, state_d;
  logic [2:0] port_q, port_d;
  logic [DROP_CNT_WIDTH-1:0] dropCount_q;

  logic [NUM_PORTS-1:0]    slotValid_q;
  logic [NUM_PORTS*DW-1:0] slotData_q;
  logic [NUM_PORTS*KW-1:0] slotKeep_q;
  logic [NUM_PORTS*IW-1:0] slotId_q;
  logic [NUM_PORTS*IW-1:0] slotDest_q;
  logic [NUM_PORTS*UW-1:0] slotUser_q;
  logic [NUM_PORTS-1:0]    slotLast_q;

  logic       decHit;
  logic [2:0] decPort;
  logic [7:0] canAccept;
  logic [2:0] portSel;
  logic       inReady;
  logic       xfer;
  logic       loadEn;
  logic       dropInc;

  // Type lookup on the current input beat; descending scan so the lowest index wins
  always_comb begin
    decHit  = 1'b0;
    decPort = 3'd0;
    for (int i = NUM_TYPES - 1; i >= 0; i--) begin
      if (TYPE_CODES[i*MSG_TYPE_WIDTH +: MSG_TYPE_WIDTH] ==
            from_network_bridge.tdata[MSG_TYPE_WIDTH-1:0] &&
          {1'b0, TYPE_PORT[i*3 +: 3]} < NUM_PORTS_L) begin
        decHit  = 1'b1;
        decPort = TYPE_PORT[i*3 +: 3];
      end
    end
  end

  // A slot can take a beat when it is empty or is draining this cycle
  always_comb begin
    canAccept = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      canAccept[p] = !slotValid_q[p] || to_port.tready[p];
    end
  end

  assign portSel = (state_q == HEAD) ? decPort : port_q;
  assign xfer    = from_network_bridge.tvalid && inReady;

  // Next-state, input ready and slot-load decisions for the packet FSM
  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    inReady = 1'b0;
    loadEn  = 1'b0;
    dropInc = 1'b0;
    case (state_q)
      HEAD: begin
        if (decHit) begin
          inReady = canAccept[decPort];
          if (xfer) begin
            loadEn = 1'b1;
            if (!from_network_bridge.tlast) begin
              state_d = FWD;
              port_d  = decPort;
            end
          end
        end else begin
          inReady = 1'b1;
          if (xfer) begin
            dropInc = 1'b1;
            if (!from_network_bridge.tlast) state_d = DROP;
          end
        end
      end
      FWD: begin
        inReady = canAccept[port_q];
        if (xfer) begin
          loadEn = 1'b1;
          if (from_network_bridge.tlast) state_d = HEAD;
        end
      end
      DROP: begin
        inReady = 1'b1;
        if (xfer && from_network_bridge.tlast) state_d = HEAD;
      end
      default: state_d = HEAD;
    endcase
    if (i_ap_rst) inReady = 1'b0;
  end

  assign from_network_bridge.tready = inReady;

  // FSM state, latched route and saturating drop counter
  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      state_q     <= HEAD;
      port_q      <= 3'd0;
      dropCount_q <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      if (dropInc && dropCount_q != '1) dropCount_q <= dropCount_q + 1'b1;
    end
  end

  // Per-port output slots: load wins over drain so valid stays high on a swap
  always_ff @(posedge i_clk or posedge i_ap_rst) begin
    if (i_ap_rst) begin
      slotValid_q <= '0;
      slotData_q  <= '0;
      slotKeep_q  <= '0;
      slotId_q    <= '0;
      slotDest_q  <= '0;
      slotUser_q  <= '0;
      slotLast_q  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (loadEn && portSel == 3'(p)) begin
          slotValid_q[p]          <= 1'b1;
          slotData_q[p*DW +: DW]  <= from_network_bridge.tdata;
          slotKeep_q[p*KW +: KW]  <= from_network_bridge.tkeep;
          slotId_q[p*IW +: IW]    <= from_network_bridge.tid;
          slotDest_q[p*IW +: IW]  <= from_network_bridge.tdest;
          slotUser_q[p*UW +: UW]  <= from_network_bridge.tuser;
          slotLast_q[p]           <= from_network_bridge.tlast;
        end else if (to_port.tready[p]) begin
          slotValid_q[p] <= 1'b0;
        end
      end
    end
  end

  assign to_port.tvalid = slotValid_q;
  assign to_port.tdata  = slotData_q;
  assign to_port.tkeep  = slotKeep_q;
  assign to_port.tid    = slotId_q;
  assign to_port.tdest  = slotDest_q;
  assign to_port.tuser  = slotUser_q;
  assign to_port.tlast  = slotLast_q;
  assign o_drop_count   = dropCount_q;

endmodule

// File: tb/tb_control_msg_router.sv
// Self-checking bench for control_msg_router: three ports, types 0x01/0x02/0x03
// routed to ports 0/1/2, 4-bit drop counter. A queue-per-port model predicts
// every output beat, the input ready and the drop count on each cycle.
module tb_control_msg_router;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 8;
  localparam int UW = 16;
  localparam int NP = 3;
  localparam int BW = DW + KW + 2*IW + UW + 1;
  typedef logic [BW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] dropCount;

  control_msg_router_if #(.LANES(1), .DATA_W(DW), .KEEP_W(KW), .DEST_W(IW), .USER_W(UW)) inBus();
  control_msg_router_if #(.LANES(NP), .DATA_W(DW), .KEEP_W(KW), .DEST_W(IW), .USER_W(UW)) outBus();

  control_msg_router #(
    .AXIS_DATA_WIDTH(DW), .AXIS_KEEP_WIDTH(KW), .AXIS_TDEST_WIDTH(IW),
    .AXIS_TUSER_WIDTH(UW), .MSG_TYPE_WIDTH(8), .NUM_PORTS(NP), .NUM_TYPES(3),
    .TYPE_CODES(24'h03_02_01), .TYPE_PORT({3'd2, 3'd1, 3'd0}), .DROP_CNT_WIDTH(4)
  ) dut (
    .i_clk(clk), .i_ap_rst(rst),
    .from_network_bridge(inBus), .to_port(outBus), .o_drop_count(dropCount)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;
  int inXfers = 0;
  int stallSeen = 0;
  int portBeats [NP];
  int readyMode = 0;
  int pat [4] = '{1, 0, 0, 1};

  beat_t expQ [NP][$];
  bit    inPkt = 0;
  int    curRoute = -1;
  int    modelDrops = 0;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Routing rule: lowest-index table entry whose port exists; -1 means drop
  function automatic int lookupRoute(input logic [7:0] t);
    int codes [3] = '{8'h01, 8'h02, 8'h03};
    int ports [3] = '{0, 1, 2};
    for (int i = 0; i < 3; i++) if (t == codes[i][7:0] && ports[i] < NP) return ports[i];
    return -1;
  endfunction

  function automatic beat_t outBeat(input int p);
    return {outBus.tdata[p*DW +: DW], outBus.tkeep[p*KW +: KW], outBus.tid[p*IW +: IW],
            outBus.tdest[p*IW +: IW], outBus.tuser[p*UW +: UW], outBus.tlast[p]};
  endfunction

  function automatic beat_t inBeat();
    return {inBus.tdata, inBus.tkeep, inBus.tid, inBus.tdest, inBus.tuser, inBus.tlast};
  endfunction

  // Cycle counter for throughput checks
  always @(posedge clk) cyc++;

  // Downstream ready generator
  always @(posedge clk) begin
    #1;
    case (readyMode)
      0: outBus.tready = '1;
      1: outBus.tready = 3'($urandom);
      default: outBus.tready = {pat[cyc % 4] != 0, 2'b11};
    endcase
  end

  // Compare process: DUT outputs vs model every cycle, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < NP; p++) expQ[p].delete();
      inPkt = 0;
      curRoute = -1;
      modelDrops = 0;
      checkOutput("rstValid", 128'(outBus.tvalid), 128'(0));
      checkOutput("rstReady", 128'(inBus.tready), 128'(0));
      checkOutput("rstDrop", 128'(dropCount), 128'(0));
    end else begin
      int route;
      bit expReady;
      for (int p = 0; p < NP; p++) begin
        checkOutput($sformatf("valid%0d", p), 128'(outBus.tvalid[p]), 128'(expQ[p].size() != 0));
        if (expQ[p].size() != 0 && outBus.tvalid[p])
          checkOutput($sformatf("beat%0d", p), 128'(outBeat(p)), 128'(expQ[p][0]));
      end
      route = inPkt ? curRoute : lookupRoute(inBus.tdata[7:0]);
      expReady = (route < 0) ? 1'b1 : (!outBus.tvalid[route] || outBus.tready[route]);
      checkOutput("inReady", 128'(inBus.tready), 128'(expReady));
      checkOutput("dropCount", 128'(dropCount), 128'(modelDrops));
      if (outBus.tvalid[2] && !outBus.tready[2] && !inBus.tready) stallSeen++;
      for (int p = 0; p < NP; p++) begin
        if (outBus.tvalid[p] && outBus.tready[p] && expQ[p].size() != 0) begin
          void'(expQ[p].pop_front());
          portBeats[p]++;
        end
      end
      if (inBus.tvalid && inBus.tready) begin
        inXfers++;
        if (!inPkt) begin
          curRoute = route;
          if (route < 0 && modelDrops < 15) modelDrops++;
        end
        if (route >= 0) expQ[route].push_back(inBeat());
        inPkt = !inBus.tlast;
      end
    end
  end

  // Drive one beat and wait (bounded) for it to be accepted
  task automatic applyStimulus(input logic [63:0] data, input logic last);
    bit done = 0;
    inBus.tdata  = data;
    inBus.tkeep  = 8'($urandom);
    inBus.tid    = 8'($urandom);
    inBus.tdest  = 8'($urandom);
    inBus.tuser  = 16'($urandom);
    inBus.tlast  = last;
    inBus.tvalid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (inBus.tready) done = 1;
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checkOutput("inputTimeout", 128'(0), 128'(1));
      inBus.tvalid = 1'b0;
    end
  endtask

  task automatic sendPacket(input logic [7:0] typ, input int len, input bit fixLow, input logic [7:0] low);
    for (int b = 0; b < len; b++) begin
      logic [63:0] d = {$urandom, $urandom};
      if (b == 0) d[7:0] = typ;
      else if (fixLow) d[7:0] = low;
      applyStimulus(d, b == len - 1);
    end
  endtask

  task automatic idle(input int n);
    inBus.tvalid = 1'b0;
    inBus.tdata  = 64'h0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int b0, b1, b2, c0, x0;
    inBus.tvalid = 0; inBus.tdata = 0; inBus.tkeep = 0; inBus.tid = 0;
    inBus.tdest = 0; inBus.tuser = 0; inBus.tlast = 0;
    outBus.tready = '1;
    for (int p = 0; p < NP; p++) portBeats[p] = 0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetValid", 128'(outBus.tvalid), 128'(0));
    checkOutput("resetReady", 128'(inBus.tready), 128'(0));
    rst = 1'b0;
    idle(2);

    $display("[TB] routing by type");
    b0 = portBeats[0]; b1 = portBeats[1]; b2 = portBeats[2];
    sendPacket(8'h02, 3, 0, 8'h00);
    idle(4);
    checkOutput("routePort1Beats", 128'(portBeats[1] - b1), 128'(3));
    checkOutput("routePort0Beats", 128'(portBeats[0] - b0), 128'(0));
    checkOutput("routePort2Beats", 128'(portBeats[2] - b2), 128'(0));

    $display("[TB] no re-decode after header");
    b0 = portBeats[0]; b2 = portBeats[2];
    sendPacket(8'h01, 4, 1, 8'h03);
    idle(4);
    checkOutput("noRedecodePort0", 128'(portBeats[0] - b0), 128'(4));
    checkOutput("noRedecodePort2", 128'(portBeats[2] - b2), 128'(0));

    $display("[TB] backpressure");
    b2 = portBeats[2]; stallSeen = 0;
    readyMode = 2;
    sendPacket(8'h03, 8, 0, 8'h00);
    idle(8);
    readyMode = 0;
    idle(3);
    checkOutput("stallPort2Beats", 128'(portBeats[2] - b2), 128'(8));
    checkOutput("stallObserved", 128'(stallSeen > 0), 128'(1));

    $display("[TB] drop and saturation");
    c0 = cyc; b0 = portBeats[0] + portBeats[1] + portBeats[2];
    for (int k = 0; k < 17; k++) sendPacket(8'h7F, 1, 0, 8'h00);
    checkOutput("dropCycles", 128'(cyc - c0), 128'(17));
    idle(3);
    checkOutput("dropSaturated", 128'(dropCount), 128'(15));
    checkOutput("dropNoOutput", 128'(portBeats[0] + portBeats[1] + portBeats[2] - b0), 128'(0));

    $display("[TB] mid-packet reset");
    sendPacket(8'h01, 1, 0, 8'h00);
    inBus.tlast = 1'b0;
    sendPacket(8'h01, 0, 0, 8'h00);
    applyStimulus({$urandom, 24'h0, 8'h01}, 1'b0);
    inBus.tdata = {$urandom, $urandom};
    inBus.tlast = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midRstValid", 128'(outBus.tvalid), 128'(0));
    checkOutput("midRstReady", 128'(inBus.tready), 128'(0));
    inBus.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checkOutput("midRstDrop", 128'(dropCount), 128'(0));
    b1 = portBeats[1];
    sendPacket(8'h02, 2, 0, 8'h00);
    idle(4);
    checkOutput("afterRstPort1", 128'(portBeats[1] - b1), 128'(2));

    $display("[TB] back-to-back full rate");
    b0 = portBeats[0]; b1 = portBeats[1]; c0 = cyc; x0 = inXfers;
    sendPacket(8'h01, 2, 0, 8'h00);
    sendPacket(8'h02, 1, 0, 8'h00);
    sendPacket(8'h01, 3, 0, 8'h00);
    checkOutput("b2bCycles", 128'(cyc - c0), 128'(6));
    checkOutput("b2bXfers", 128'(inXfers - x0), 128'(6));
    idle(4);
    checkOutput("b2bPort0", 128'(portBeats[0] - b0), 128'(5));
    checkOutput("b2bPort1", 128'(portBeats[1] - b1), 128'(1));

    $display("[TB] randomized traffic");
    readyMode = 1;
    for (int k = 0; k < 60; k++) begin
      logic [7:0] typ;
      case ($urandom_range(0, 4))
        0: typ = 8'h01;
        1: typ = 8'h02;
        2: typ = 8'h03;
        3: typ = 8'h7F;
        default: typ = 8'($urandom);
      endcase
      sendPacket(typ, $urandom_range(1, 4), 0, 8'h00);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    readyMode = 0;
    idle(6);
    checkOutput("drainedQ0", 128'(expQ[0].size()), 128'(0));
    checkOutput("drainedQ1", 128'(expQ[1].size()), 128'(0));
    checkOutput("drainedQ2", 128'(expQ[2].size()), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
